fifo_drain: RTL and testbench

Read-side controller for the 32-bit, 8-deep FIFO buffer. On a start command it pops a programmed number of words through the FIFO's RD/EMPTY/dataOut port and presents them, in order, on a valid/ready output stream. A 2-entry skid buffer hides the FIFO's one-cycle read latency, so the block sustains one word per cycle under sink backpressure. It sits between the FIFO and any downstream consumer, such as a serializer or a bus master.

---
 rtl/fifo_drain.sv | 152 +++++++++++++++
 tb/tb_fifo_drain.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_drain.sv
// fifo_drain: read-side controller for the 32-bit, 8-deep FIFO.
// On start, pops a programmed number of words (len, 0 = 256) from the FIFO
// and presents them in order on a valid/ready stream. A 2-entry skid buffer
// covers the FIFO's one-cycle read latency so one word per cycle is sustained
// under sink backpressure.
module fifo_drain #(
    parameter int WIDTH = 32
) (
    input  logic             Clk,
    input  logic             Rst_n,
    input  logic             EN,
    input  logic             start,
    input  logic [7:0]       len,
    input  logic             fifo_EMPTY,
    output logic             fifo_RD,
    input  logic [WIDTH-1:0] fifo_data,
    output logic             m_valid,
    output logic [WIDTH-1:0] m_data,
    input  logic             m_ready,
    output logic             busy,
    output logic             done,
    output logic [8:0]       count
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t           state_q,     state_d;
    logic [8:0]       remaining_q, remaining_d;
    logic [8:0]       count_q,     count_d;
    logic             inflight_q,  inflight_d;
    logic [1:0]       occ_q,       occ_d;
    logic [WIDTH-1:0] buf0_q,      buf0_d;
    logic [WIDTH-1:0] buf1_q,      buf1_d;

    logic             pop;
    logic             rd;
    logic [2:0]       room;

    // Read issue: the word about to land plus what stays buffered after this
    // cycle's pop must leave a free slot, so m_ready feeds fifo_RD directly.
    always_comb begin
        pop  = (occ_q != 2'd0) && m_ready;
        room = {1'b0, occ_q} + {2'b00, inflight_q} - {2'b00, pop};
        rd   = (state_q == RUN) && EN && !fifo_EMPTY &&
               (remaining_q != 9'd0) && (room < 3'd2);
    end

    // Burst sequencing: state, words still to read, words delivered.
    always_comb begin
        state_d     = state_q;
        remaining_d = remaining_q;
        count_d     = count_q;

        if (pop && (count_q != 9'd256)) begin
            count_d = count_q + 9'd1;
        end
        if (rd) begin
            remaining_d = remaining_q - 9'd1;
        end

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d     = RUN;
                    remaining_d = (len == 8'd0) ? 9'd256 : {1'b0, len};
                    count_d     = '0;
                end
            end
            RUN: begin
                if (rd && (remaining_q == 9'd1)) begin
                    state_d = FLUSH;
                end
            end
            FLUSH: begin
                if ((occ_q == 2'd0) && !inflight_q) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Skid buffer: buf0 is the head; the returning FIFO word lands behind
    // whatever survives this cycle's pop.
    always_comb begin
        inflight_d = rd;
        occ_d      = occ_q;
        buf0_d     = buf0_q;
        buf1_d     = buf1_q;

        if (inflight_q && pop) begin
            if (occ_q == 2'd2) begin
                buf0_d = buf1_q;
                buf1_d = fifo_data;
            end else begin
                buf0_d = fifo_data;
            end
        end else if (inflight_q) begin
            occ_d = occ_q + 2'd1;
            if (occ_q == 2'd0) begin
                buf0_d = fifo_data;
            end else begin
                buf1_d = fifo_data;
            end
        end else if (pop) begin
            occ_d  = occ_q - 2'd1;
            buf0_d = buf1_q;
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            state_q     <= IDLE;
            remaining_q <= '0;
            count_q     <= '0;
            inflight_q  <= 1'b0;
            occ_q       <= '0;
            buf0_q      <= '0;
            buf1_q      <= '0;
        end else begin
            state_q     <= state_d;
            remaining_q <= remaining_d;
            count_q     <= count_d;
            inflight_q  <= inflight_d;
            occ_q       <= occ_d;
            buf0_q      <= buf0_d;
            buf1_q      <= buf1_d;
        end
    end

    // Output decode from registered state.
    always_comb begin
        fifo_RD = rd;
        m_valid = (occ_q != 2'd0);
        m_data  = buf0_q;
        busy    = (state_q == RUN) || (state_q == FLUSH);
        done    = (state_q == DONE);
        count   = count_q;
    end

endmodule

// File: tb/tb_fifo_drain.sv
// Testbench for fifo_drain: behavioural 8-deep FIFO, in-order scoreboard of
// words written to the FIFO, and per-cycle protocol checks.
module tb_fifo_drain;

    localparam int WIDTH = 32;
    localparam int NO_EN = 100000;

    logic             Clk = 1'b0;
    logic             Rst_n = 1'b0;
    logic             EN = 1'b0;
    logic             start = 1'b0;
    logic [7:0]       len = '0;
    logic             fifo_EMPTY;
    logic             fifo_RD;
    logic [WIDTH-1:0] fifo_data = '0;
    logic             m_valid;
    logic [WIDTH-1:0] m_data;
    logic             m_ready = 1'b0;
    logic             busy;
    logic             done;
    logic [8:0]       count;

    logic             wr_en = 1'b0;
    logic [31:0]      wr_data = '0;
    logic [31:0]      mem [8];
    int               fcnt = 0;
    int               wp = 0;
    int               rp = 0;

    int               checks = 0;
    int               errors = 0;
    int               rd_cnt = 0;
    int               acc_cnt = 0;
    int               done_cnt = 0;
    logic [31:0]      exp_q [$];
    int               outst;
    logic             pop_now;
    logic [31:0]      exp_w;

    bit               seen;
    logic             busy_at_done;
    int               rl;

    fifo_drain #(.WIDTH(WIDTH)) dut (
        .Clk        (Clk),
        .Rst_n      (Rst_n),
        .EN         (EN),
        .start      (start),
        .len        (len),
        .fifo_EMPTY (fifo_EMPTY),
        .fifo_RD    (fifo_RD),
        .fifo_data  (fifo_data),
        .m_valid    (m_valid),
        .m_data     (m_data),
        .m_ready    (m_ready),
        .busy       (busy),
        .done       (done),
        .count      (count)
    );

    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // FIFO model: registered dataOut, valid the cycle after RD.
    assign fifo_EMPTY = (fcnt == 0);
    always @(posedge Clk) begin
        if (fifo_RD && fcnt != 0) begin
            fifo_data <= mem[rp];
            rp <= (rp + 1) % 8;
        end
        if (wr_en) begin
            mem[wp] <= wr_data;
            wp <= (wp + 1) % 8;
        end
        fcnt <= fcnt + (wr_en ? 1 : 0) - ((fifo_RD && fcnt != 0) ? 1 : 0);
    end

    // Scoreboard and protocol checks, sampled mid-cycle.
    always @(negedge Clk) begin
        if (wr_en) exp_q.push_back(wr_data);
        if (Rst_n) begin
            outst   = rd_cnt - acc_cnt;
            pop_now = m_valid && m_ready;
            check("outstanding_le_2", 32'(outst <= 2), 1);
            if (fifo_RD) begin
                check("rd_needs_en", 32'(EN), 1);
                check("rd_needs_data", 32'(fifo_EMPTY), 0);
                check("rd_room", 32'((outst - int'(pop_now)) < 2), 1);
                rd_cnt++;
            end
            if (pop_now) begin
                check("sb_has_word", 32'(exp_q.size() > 0), 1);
                if (exp_q.size() > 0) begin
                    exp_w = exp_q.pop_front();
                    check("m_data_order", m_data, exp_w);
                end
                acc_cnt++;
            end
            if (done) done_cnt++;
        end
    end

    task automatic fifo_write(input logic [31:0] d);
        wr_en = 1'b1;
        wr_data = d;
        @(posedge Clk); #1;
        wr_en = 1'b0;
    endtask

    task automatic clear_counts();
        rd_cnt = 0;
        acc_cnt = 0;
        done_cnt = 0;
    endtask

    task automatic wait_done(input int bound, output bit s, output logic b);
        s = 1'b0;
        b = 1'bx;
        for (int i = 0; i < bound; i++) begin
            @(negedge Clk);
            if (done === 1'b1) begin
                s = 1'b1;
                b = busy;
                break;
            end
        end
        @(posedge Clk); #1;
    endtask

    // rmode: 0 ready high, 1 pattern 1,0,0,1, 2 random.
    task automatic run_burst(input int l, input int rmode, input int nwr, input int wr_delay,
                             input int en_off, output bit s, output logic b);
        int k;
        int left;
        k = 0;
        left = nwr;
        s = 1'b0;
        b = 1'bx;
        clear_counts();
        start = 1'b1;
        len = l[7:0];
        @(posedge Clk); #1;
        start = 1'b0;
        while (!s && k < 4000) begin
            case (rmode)
                0:       m_ready = 1'b1;
                1:       m_ready = ((k % 4) == 0) || ((k % 4) == 3);
                default: m_ready = 1'($urandom_range(0, 1));
            endcase
            EN = !(k >= en_off && k < en_off + 3);
            wr_en = (left > 0) && (k >= wr_delay) && (fcnt < 8);
            if (wr_en) begin
                wr_data = $urandom;
                left--;
            end
            @(negedge Clk);
            if (done === 1'b1) begin
                s = 1'b1;
                b = busy;
            end
            @(posedge Clk); #1;
            wr_en = 1'b0;
            k++;
        end
        EN = 1'b1;
    endtask

    task automatic finish_checks(input int l, input bit s, input logic b);
        check("done_seen", 32'(s), 1);
        check("busy_low_at_done", 32'(b), 0);
        check("count_final", 32'(count), l);
        check("words_read", rd_cnt, l);
        check("words_delivered", acc_cnt, l);
        check("done_pulses", done_cnt, 1);
        check("sb_drained", exp_q.size(), 0);
        @(negedge Clk);
        check("done_one_cycle", 32'(done), 0);
        check("idle_not_busy", 32'(busy), 0);
        @(posedge Clk); #1;
    endtask

    initial begin
        // Reset values
        repeat (2) @(posedge Clk);
        #1;
        @(negedge Clk);
        check("rst_fifo_rd", 32'(fifo_RD), 0);
        check("rst_m_valid", 32'(m_valid), 0);
        check("rst_m_data", m_data, 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
        check("rst_count", 32'(count), 0);
        @(posedge Clk); #1;
        Rst_n = 1'b1;
        EN = 1'b1;
        m_ready = 1'b1;

        // len=4, A0..A3, sink always ready: directed latency checks
        for (int i = 0; i < 4; i++) fifo_write(32'hA0 + 32'(i));
        clear_counts();
        start = 1'b1;
        len = 8'd4;
        @(posedge Clk); #1;
        start = 1'b0;
        @(negedge Clk);
        check("t1_busy_after_start", 32'(busy), 1);
        check("t1_first_rd", 32'(fifo_RD), 1);
        @(negedge Clk);
        check("t1_valid_not_yet", 32'(m_valid), 0);
        check("t1_second_rd", 32'(fifo_RD), 1);
        @(negedge Clk);
        check("t1_first_valid", 32'(m_valid), 1);
        check("t1_first_word", m_data, 32'hA0);
        check("t1_third_rd", 32'(fifo_RD), 1);
        wait_done(50, seen, busy_at_done);
        finish_checks(4, seen, busy_at_done);

        // len=8, sink ready pattern 1,0,0,1
        for (int i = 0; i < 8; i++) fifo_write($urandom);
        run_burst(8, 1, 0, 0, NO_EN, seen, busy_at_done);
        finish_checks(8, seen, busy_at_done);

        // len=3, one word present, two more arrive 5 cycles in
        fifo_write($urandom);
        run_burst(3, 0, 2, 5, NO_EN, seen, busy_at_done);
        finish_checks(3, seen, busy_at_done);

        // len=0 (256 words), continuous refill, random backpressure
        for (int i = 0; i < 8; i++) fifo_write($urandom);
        run_burst(0, 2, 248, 0, NO_EN, seen, busy_at_done);
        finish_checks(256, seen, busy_at_done);

        // EN low for 3 cycles while a read is in flight
        for (int i = 0; i < 6; i++) fifo_write($urandom);
        run_burst(6, 0, 0, 0, 2, seen, busy_at_done);
        finish_checks(6, seen, busy_at_done);

        // Random short bursts with random backpressure
        for (int r = 0; r < 3; r++) begin
            rl = int'($urandom_range(1, 8));
            for (int i = 0; i < rl; i++) fifo_write($urandom);
            run_burst(rl, 2, 0, 0, NO_EN, seen, busy_at_done);
            finish_checks(rl, seen, busy_at_done);
        end

        // Reset during FLUSH with two words held
        m_ready = 1'b0;
        fifo_write($urandom);
        fifo_write($urandom);
        clear_counts();
        start = 1'b1;
        len = 8'd2;
        @(posedge Clk); #1;
        start = 1'b0;
        repeat (4) begin
            @(posedge Clk); #1;
        end
        @(negedge Clk);
        check("flush_holding", 32'(m_valid), 1);
        check("flush_busy", 32'(busy), 1);
        check("flush_reads", rd_cnt, 2);
        @(posedge Clk); #1;
        Rst_n = 1'b0;
        @(posedge Clk); #1;
        Rst_n = 1'b1;
        clear_counts();
        exp_q.delete();
        @(negedge Clk);
        check("mid_rst_m_valid", 32'(m_valid), 0);
        check("mid_rst_busy", 32'(busy), 0);
        check("mid_rst_count", 32'(count), 0);
        check("mid_rst_done", 32'(done), 0);
        check("mid_rst_fifo_rd", 32'(fifo_RD), 0);
        @(posedge Clk); #1;
        m_ready = 1'b1;
        for (int i = 0; i < 3; i++) fifo_write($urandom);
        run_burst(3, 2, 0, 0, NO_EN, seen, busy_at_done);
        finish_checks(3, seen, busy_at_done);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
